// File: rtl/shift_serdes_pkg.sv
// Shared types for the shift_serdes serialiser/deserialiser.
// State encodings are fixed so later serial blocks can decode them.
package shift_serdes_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_DONE  = ENC_DONE
    } state_t;

endpackage

// File: rtl/shift_serdes_if.sv
// Parallel/serial signal bundle for shift_serdes.
// master drives the request side, slave is the serdes itself.
interface shift_serdes_if #(
    parameter int WIDTH = 8
);

    logic             i_start;
    logic [WIDTH-1:0] i_load_data;
    logic             i_shift_en;
    logic             i_s_in;
    logic             o_s_out;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_par_out;

    modport master (
        output i_start, i_load_data, i_shift_en, i_s_in,
        input  o_s_out, o_busy, o_done, o_par_out
    );

    modport slave (
        input  i_start, i_load_data, i_shift_en, i_s_in,
        output o_s_out, o_busy, o_done, o_par_out
    );

endinterface

// File: rtl/shift_bit_cnt.sv
// Bit counter with clear, enable and terminal count at WIDTH-1.
// Clear has priority over enable.
module shift_bit_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_serdes.sv
// Parallel-load shift register serdes with IDLE/SHIFT/DONE controller.
// Define SHIFT_SERDES_LSB_FIRST_EN to shift LSB-first instead of MSB-first.
module shift_serdes
    import shift_serdes_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    shift_serdes_if.slave  bus
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_par_out;
    logic [WIDTH-1:0] w_shift_val;
    logic             w_load;
    logic             w_tick;
    logic             w_tc;
    logic             w_busy;
    logic             w_done;

    assign w_load = (r_state == ST_IDLE) && bus.i_start;
    assign w_tick = (r_state == ST_SHIFT) && bus.i_shift_en;

`ifdef SHIFT_SERDES_LSB_FIRST_EN
    assign w_shift_val = {bus.i_s_in, r_shreg[WIDTH-1:1]};
    assign bus.o_s_out = r_shreg[0];
`else
    assign w_shift_val = {r_shreg[WIDTH-2:0], bus.i_s_in};
    assign bus.o_s_out = r_shreg[WIDTH-1];
`endif

    shift_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_load || (w_tick && w_tc)),
        .i_en  (w_tick),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.i_start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_tick && w_tc) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            ST_SHIFT: w_busy = 1'b1;
            ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Final capture reuses the shift value so par_out matches shreg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg   <= '0;
            r_par_out <= '0;
        end else if (w_load) begin
            r_shreg <= bus.i_load_data;
        end else if (w_tick) begin
            r_shreg <= w_shift_val;
            if (w_tc) begin
                r_par_out <= w_shift_val;
            end
        end
    end

    assign bus.o_busy    = w_busy;
    assign bus.o_done    = w_done;
    assign bus.o_par_out = r_par_out;

endmodule

// File: doc/shift_serdes.md
Name: shift_serdes

Overview:
Parametrised successor to the team's single-bit load/shift cell. A WIDTH-bit parallel-load shift register with a small controller.
- A `start` pulse loads a parallel word.
- The word is shifted out serially while serial input bits are captured, paced by a `shift_en` tick.
- When WIDTH bits have been exchanged, the captured word is presented on `par_out` with a one-cycle `done` pulse.
- Used as a generic serialiser/deserialiser between parallel control registers and serial peripherals.

Parameters:
- WIDTH, 8: shift register and word width; legal range 2..64.
- CNT_W, $clog2(WIDTH): bit-counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load `load_data` and begin a transfer; honoured only in IDLE.
- load_data  in  WIDTH  parallel word to transmit.
- shift_en  in  1  shift tick; one bit exchanged per cycle when high in SHIFT.
- s_in  in  1  serial input, sampled on a shift cycle.
- s_out  out  1  serial output; current outgoing bit.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse; `par_out` is valid from this cycle.
- par_out  out  WIDTH  last received word; held until next completion.

Behaviour:
- Reset (async, immediate): state=IDLE, shreg=0, cnt=0, par_out=0, done=0, busy=0, s_out=0.
- Reset mid-transfer aborts the transfer. No `done` is issued and `par_out` returns to 0.
- `s_out` = shreg[WIDTH-1] (MSB-first). It is driven straight from the register, so it is glitch-free.
- State IDLE:
  - busy=0, done=0.
  - start=1: shreg<=load_data, cnt<=0, go to SHIFT. The first bit appears on `s_out` the next cycle.
- State SHIFT:
  - busy=1.
  - shift_en=1: shreg<={shreg[WIDTH-2:0], s_in}, cnt<=cnt+1.
  - shift_en=1 and cnt==WIDTH-1: par_out<={shreg[WIDTH-2:0], s_in}, cnt<=0, go to DONE.
  - shift_en=0: hold all state.
- State DONE:
  - done=1, busy=1, for exactly one cycle; then go to IDLE unconditionally.
- `start` in SHIFT or DONE is ignored. It is not queued, and `load_data` is not sampled.
- `start` and `shift_en` high together in IDLE: load only; no shift that cycle.
- Latency:
  - With shift_en held high, `done` asserts WIDTH+1 cycles after the `start` cycle.
  - Earliest next `start` is accepted WIDTH+2 cycles after the previous one.
- `par_out` changes only on the transition into DONE (or on reset).
- Counter never exceeds WIDTH-1. There is no wrap condition outside the DONE transition.
- `s_in` is a don't-care on non-shift cycles.

Optional Feature:
- Macro: SHIFT_SERDES_LSB_FIRST_EN.
- Defined:
  - Shift direction reverses: s_out=shreg[0], shreg<={s_in, shreg[WIDTH-1:1]}.
  - The final capture uses the same reversed concatenation.
  - Bit 0 is transmitted first; the first received bit lands in par_out[0].
- Undefined: MSB-first as above.
- Timing, handshake and reset are identical in both builds.

Decomposition:
- Package `shift_serdes_pkg` holds:
  - the state typedef (IDLE, SHIFT, DONE), 2-bit encoding;
  - localparam encodings.
- Optional sub-module `shift_bit_cnt`:
  - CNT_W counter with clear, enable and terminal-count (== WIDTH-1) output;
  - also reused by later serial blocks.
- Datapath and FSM stay in the top module.

Test Plan:
1. WIDTH=8, shift_en=1 constant, start with load_data=0xA5, s_in driven MSB-first from 0x3C.
   - s_out sequence is 1,0,1,0,0,1,0,1.
   - done pulses exactly at cycle 9 after start.
   - par_out=0x3C, busy=0 at cycle 10.
2. shift_en high every 3rd cycle, load_data=0xFF, s_in=0.
   - done after 8 ticks, i.e. not before 24 cycles.
   - par_out=0x00; shreg holds between ticks.
3. start re-asserted with load_data=0x12 at cycles 3 and 9 of a 0xA5 transfer.
   - Ignored; s_out sequence and par_out unaffected.
   - A start at cycle 10 (IDLE) is accepted.
4. rst pulsed after 4 shifts of a 0xA5 transfer, mid-cycle.
   - Outputs go to 0 immediately; no done pulse.
   - par_out=0; a new start then completes normally.
5. SHIFT_SERDES_LSB_FIRST_EN build, load_data=0xA5, s_in bits 0,0,1,1,1,1,0,0.
   - s_out sequence is 1,0,1,0,0,1,0,1 (LSB first).
   - par_out=0x3C.
6. start and shift_en high together in IDLE with load_data=0x80.
   - First s_out bit is 1 for a full tick; exactly 8 shifts before done.
